pulse_train_gen: RTL and testbench
==================================

# pulse_train_gen

Turns a one-cycle trigger flag into a programmable pulse train: optional start delay, then N pulses of programmable high width and period. It is the generator side of our edge-flag path: edge-detect flags coming out of the test logic drive this block, and it re-creates timed strobes for the DUT and the instruments. All timing is counted in I_clk cycles. Configuration is latched when the trigger is accepted.

## Interface
- CNT_W, 16: width of the delay, width and period counters.
- NUM_W, 8: width of the pulse-count input.

- I_clk  in  1  clock; all logic on rising edge.
- I_rst  in  1  reset, synchronous, active-high.
- I_trig  in  1  start request; sampled every edge; acted on only when idle.
- I_delay  in  CNT_W  cycles from the accepting edge to the first rise.
- I_width  in  CNT_W  high time per pulse, in cycles.
- I_period  in  CNT_W  rise-to-rise spacing, in cycles.
- I_count  in  NUM_W  number of pulses.
- I_abort  in  1  cancels a running train.
- O_pulse  out  1  generated waveform, registered.
- O_busy  out  1  high while a train is in progress.
- O_done  out  1  one-cycle flag at normal completion.

## Operation
- FSM states: IDLE, DELAY, HIGH, LOW.
- IDLE:
  - When I_trig=1 and I_abort=0, latch all configuration inputs.
  - Go to HIGH if the latched delay is 0; otherwise go to DELAY.
- DELAY: count D cycles, then go to HIGH.
- HIGH: O_pulse=1 for W cycles.
  - If pulses remain, go to LOW.
  - After the last pulse, go to IDLE with O_done=1.
- LOW: O_pulse=0 for P−W cycles, then go to HIGH.
- Clamps, applied at latch time:
  - W=0 is treated as 1.
  - N=0 is treated as 1.
  - P≤W (after the W clamp) is treated as W+1, so there is always at least one low cycle.
- Counters are unsigned CNT_W bits. D, W and P can each take their maximum value 2^CNT_W−1 without wrap. Use a down-counter that is reloaded per phase.
- The pulse counter is NUM_W bits, loaded with N and decremented at the end of each high phase.
- While busy, I_trig is ignored. Triggers are not queued.
- I_abort while busy:
  - At the next edge: O_pulse=0, O_busy=0, state=IDLE.
  - O_done stays 0.
- I_abort and I_trig together in IDLE: abort wins and the trigger is dropped.
- Configuration inputs may change freely while busy; the latched copy is used.

## Timing
- Reset values: O_pulse=0, O_busy=0, O_done=0, state IDLE, all counters 0.
- Reset mid-train: outputs return to reset values at the reset edge, with no O_done.
- Let the trigger be accepted at edge k, with clamped values D, W, P, N.
- O_busy:
  - Goes to 1 after edge k.
  - Goes to 0 after edge k+D+(N−1)·P+W.
- Pulse i (i = 0 … N−1):
  - O_pulse goes to 1 after edge k+D+i·P.
  - O_pulse returns to 0 after edge k+D+i·P+W.
- Latency check: with D=0, O_pulse is high in the cycle right after the accepting edge.
- O_done is 1 for exactly the one cycle after the final falling edge. In that cycle O_busy=0.
- A trigger sampled during the O_done cycle is accepted, so back-to-back trains are possible. The gap between trains is then 1 cycle low.
- O_done and O_pulse are never both 1.
- O_busy=0 implies O_pulse=0.

## Test plan
- Minimal train: D=0, W=1, P=2, N=1, trigger at edge 10.
  - O_pulse high only after edge 10.
  - O_done high after edge 11.
  - O_busy high for exactly 1 cycle.
- Full train: D=3, W=2, P=5, N=3, trigger at edge 20.
  - Rises after edges 23, 28, 33.
  - Falls after edges 25, 30, 35.
  - O_done high for one cycle after edge 35.
- Clamps: W=0, P=0, N=0, D=0, trigger at edge 5.
  - Behaves as W=1, P=2, N=1.
  - O_pulse high one cycle after edge 5; O_done after edge 6.
- Ignored triggers: start the "full train" case, then pulse I_trig at edges 24 and 30 with different configuration.
  - The waveform is identical to the "full train" case.
  - A trigger in the O_done cycle (edge 36) starts a new train.
- Abort and reset:
  - In the "full train" case, assert I_abort at edge 29 (second high phase): O_pulse=0 and O_busy=0 after edge 29, and O_done is never asserted.
  - Repeat with I_rst at edge 29: same result.
  - Abort and trigger together in IDLE: nothing starts.
- Large counts: CNT_W=16, D=65535, W=65535, P=65535.
  - The clamp raises P to 65536 because P≤W. This exceeds CNT_W bits, so the low phase must still last 1 cycle with no wrap.
  - Rise after edge k+65535; fall after edge k+131070.

Source files
------------

// File: rtl/pulse_train_gen.sv
// Pulse train generator: trigger -> optional start delay -> N pulses of width W, period P.
// Latency: with zero delay, O_pulse rises in the cycle right after the accepting edge.
// Flow: triggers are accepted only in IDLE (not queued); I_abort cancels a running train.
module pulse_train_gen #(
  parameter int CNT_W = 16,
  parameter int NUM_W = 8
) (
  input  logic             I_clk,
  input  logic             I_rst,
  input  logic             I_trig,
  input  logic [CNT_W-1:0] I_delay,
  input  logic [CNT_W-1:0] I_width,
  input  logic [CNT_W-1:0] I_period,
  input  logic [NUM_W-1:0] I_count,
  input  logic             I_abort,
  output logic             O_pulse,
  output logic             O_busy,
  output logic             O_done
);

  typedef enum logic [1:0] {IDLE, DELAY, HIGH, LOW} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;      // phase down-counter, holds (remaining cycles - 1)
  logic [CNT_W-1:0] w_m1;     // latched high time minus one
  logic [CNT_W-1:0] low_m1;   // latched low time minus one
  logic [NUM_W-1:0] num;      // pulses still to be emitted, including the current one

  logic [CNT_W-1:0] w_clamp;
  logic [CNT_W-1:0] w_m1_in;
  logic [CNT_W-1:0] low_m1_in;
  logic [NUM_W-1:0] n_in;

  // Clamp the configuration before latching. The low phase is stored as P-W-1
  // rather than P itself, so P=W+1 never needs a counter wider than CNT_W bits.
  always_comb begin
    w_clamp   = (I_width == '0) ? CNT_W'(1) : I_width;
    w_m1_in   = w_clamp - CNT_W'(1);
    low_m1_in = '0;
    if (I_period > w_clamp) begin
      low_m1_in = I_period - w_clamp - CNT_W'(1);
    end
    n_in      = (I_count == '0) ? NUM_W'(1) : I_count;
  end

  // Phase sequencer with registered outputs.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      w_m1    <= '0;
      low_m1  <= '0;
      num     <= '0;
      O_pulse <= 1'b0;
      O_busy  <= 1'b0;
      O_done  <= 1'b0;
    end else begin
      O_done <= 1'b0;
      if (state != IDLE && I_abort) begin
        state   <= IDLE;
        cnt     <= '0;
        num     <= '0;
        O_pulse <= 1'b0;
        O_busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            // Abort in the same cycle as a trigger drops the trigger.
            if (I_trig && !I_abort) begin
              w_m1   <= w_m1_in;
              low_m1 <= low_m1_in;
              num    <= n_in;
              O_busy <= 1'b1;
              if (I_delay == '0) begin
                state   <= HIGH;
                cnt     <= w_m1_in;
                O_pulse <= 1'b1;
              end else begin
                state <= DELAY;
                cnt   <= I_delay - CNT_W'(1);
              end
            end
          end
          DELAY: begin
            if (cnt == '0) begin
              state   <= HIGH;
              cnt     <= w_m1;
              O_pulse <= 1'b1;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          HIGH: begin
            if (cnt == '0) begin
              O_pulse <= 1'b0;
              num     <= num - NUM_W'(1);
              if (num <= NUM_W'(1)) begin
                state  <= IDLE;
                O_busy <= 1'b0;
                O_done <= 1'b1;
              end else begin
                state <= LOW;
                cnt   <= low_m1;
              end
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          LOW: begin
            if (cnt == '0) begin
              state   <= HIGH;
              cnt     <= w_m1;
              O_pulse <= 1'b1;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen: waveform tables per train plus hand-written
// abort / reset / retrigger sequences and a long-count run on an 8-bit instance.
module tb_pulse_train_gen;

  logic        clk;
  logic        rst;
  logic        trig;
  logic        abort;
  logic [15:0] delay;
  logic [15:0] width;
  logic [15:0] period;
  logic [7:0]  count;
  logic        pulse;
  logic        busy;
  logic        done;

  // Narrow instance so the maximum-count case fits a short run.
  logic       s_trig;
  logic       s_abort;
  logic [7:0] s_delay;
  logic [7:0] s_width;
  logic [7:0] s_period;
  logic [3:0] s_count;
  logic       s_pulse;
  logic       s_busy;
  logic       s_done;

  int n_vec;
  int n_err;

  pulse_train_gen #(.CNT_W(16), .NUM_W(8)) dut (
    .I_clk(clk), .I_rst(rst), .I_trig(trig),
    .I_delay(delay), .I_width(width), .I_period(period), .I_count(count),
    .I_abort(abort), .O_pulse(pulse), .O_busy(busy), .O_done(done)
  );

  pulse_train_gen #(.CNT_W(8), .NUM_W(4)) dut_s (
    .I_clk(clk), .I_rst(rst), .I_trig(s_trig),
    .I_delay(s_delay), .I_width(s_width), .I_period(s_period), .I_count(s_count),
    .I_abort(s_abort), .O_pulse(s_pulse), .O_busy(s_busy), .O_done(s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bit i of each captured word is the output in the cycle after edge k+i,
  // where edge k accepts the trigger. Masks inject inputs at edge k+i (i>=1);
  // an injected trigger also switches the configuration to D=0,W=1,P=2,N=1.
  task automatic run(input int d, input int w, input int p, input int n,
                     input logic [23:0] tm, input logic [23:0] am, input logic [23:0] rm,
                     output logic [23:0] pw, output logic [23:0] bw, output logic [23:0] dw);
    pw = '0; bw = '0; dw = '0;
    delay = 16'(d); width = 16'(w); period = 16'(p); count = 8'(n);
    trig = 1'b1; abort = 1'b0;
    @(posedge clk);
    @(negedge clk);
    trig = 1'b0;
    pw[0] = pulse; bw[0] = busy; dw[0] = done;
    for (int i = 1; i < 24; i++) begin
      trig = tm[i]; abort = am[i]; rst = rm[i];
      if (tm[i]) begin
        delay = 16'd0; width = 16'd1; period = 16'd2; count = 8'd1;
      end
      @(posedge clk);
      @(negedge clk);
      pw[i] = pulse; bw[i] = busy; dw[i] = done;
    end
    trig = 1'b0; abort = 1'b0; rst = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    int          d, w, p, n;
    logic [23:0] ep, eb, ed;
  } vec_t;

  vec_t        tbl[6];
  logic [23:0] pw, bw, dw;

  initial begin
    int r0, f0, r1, f1, dn, viol;
    logic prev;

    // D, W, P, N -> expected pulse / busy / done windows
    tbl[0] = '{0, 1, 2, 1, 24'h000001, 24'h000001, 24'h000002};  // minimal train
    tbl[1] = '{3, 2, 5, 3, 24'h006318, 24'h007FFF, 24'h008000};  // full train
    tbl[2] = '{0, 0, 0, 0, 24'h000001, 24'h000001, 24'h000002};  // all clamps
    tbl[3] = '{1, 3, 4, 2, 24'h0000EE, 24'h0000FF, 24'h000100};  // one low cycle
    tbl[4] = '{0, 2, 2, 2, 24'h00001B, 24'h00001F, 24'h000020};  // P<=W -> P=W+1
    tbl[5] = '{2, 1, 5, 4, 24'h021084, 24'h03FFFF, 24'h040000};  // four narrow pulses

    n_vec = 0; n_err = 0;
    rst = 1'b1; trig = 1'b0; abort = 1'b0;
    delay = '0; width = '0; period = '0; count = '0;
    s_trig = 1'b0; s_abort = 1'b0;
    s_delay = '0; s_width = '0; s_period = '0; s_count = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_pulse", 32'(pulse), 32'd0);
    check("reset_busy",  32'(busy),  32'd0);
    check("reset_done",  32'(done),  32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int t = 0; t < 6; t++) begin
      run(tbl[t].d, tbl[t].w, tbl[t].p, tbl[t].n, '0, '0, '0, pw, bw, dw);
      check($sformatf("tbl%0d_pulse", t), 32'(pw), 32'(tbl[t].ep));
      check($sformatf("tbl%0d_busy",  t), 32'(bw), 32'(tbl[t].eb));
      check($sformatf("tbl%0d_done",  t), 32'(dw), 32'(tbl[t].ed));
    end

    // Triggers while busy are ignored; one in the done cycle starts a new train.
    run(3, 2, 5, 3, 24'h010410, '0, '0, pw, bw, dw);
    check("retrig_pulse", 32'(pw), 32'h016318);
    check("retrig_busy",  32'(bw), 32'h017FFF);
    check("retrig_done",  32'(dw), 32'h028000);

    // Abort during the second high phase.
    run(3, 2, 5, 3, '0, 24'h000200, '0, pw, bw, dw);
    check("abort_pulse", 32'(pw), 32'h000118);
    check("abort_busy",  32'(bw), 32'h0001FF);
    check("abort_done",  32'(dw), 32'h000000);

    // Synchronous reset at the same point.
    run(3, 2, 5, 3, '0, '0, 24'h000200, pw, bw, dw);
    check("rst_pulse", 32'(pw), 32'h000118);
    check("rst_busy",  32'(bw), 32'h0001FF);
    check("rst_done",  32'(dw), 32'h000000);

    // Abort and trigger together in IDLE: nothing starts.
    delay = 16'd0; width = 16'd1; period = 16'd2; count = 8'd1;
    trig = 1'b1; abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    trig = 1'b0; abort = 1'b0;
    check("abtrig_busy",  32'(busy),  32'd0);
    check("abtrig_pulse", 32'(pulse), 32'd0);
    repeat (3) @(negedge clk);
    check("abtrig_later", 32'({pulse, busy, done}), 32'd0);

    // Maximum counts on the 8-bit instance: P clamps to 256, one low cycle.
    s_delay = 8'd255; s_width = 8'd255; s_period = 8'd255; s_count = 4'd2;
    s_trig = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_trig = 1'b0;
    r0 = -1; f0 = -1; r1 = -1; f1 = -1; dn = -1; viol = 0; prev = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (i > 0) @(negedge clk);
      if (s_pulse && !prev) begin
        if (r0 < 0) r0 = i; else if (r1 < 0) r1 = i;
      end
      if (!s_pulse && prev) begin
        if (f0 < 0) f0 = i; else if (f1 < 0) f1 = i;
      end
      if (s_done && dn < 0) dn = i;
      if ((s_done && s_pulse) || (!s_busy && s_pulse)) viol++;
      prev = s_pulse;
    end
    check("max_rise0", 32'(r0), 32'd255);
    check("max_fall0", 32'(f0), 32'd510);
    check("max_rise1", 32'(r1), 32'd511);
    check("max_fall1", 32'(f1), 32'd766);
    check("max_done",  32'(dn), 32'd766);
    check("max_invariants", 32'(viol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
